// File: rtl/mem_msg_pkg.sv
// rtl/mem_msg_pkg.sv - shared memory-interface message definitions
//
// Message layouts (MSB first):
//   MEM_REQ(o,a)  : {type[1], opaque[o], addr[a], data[32]}
//   MEM_RESP(o)   : {type[1], opaque[o], data[32]}
// The opaque field sits directly below the type bit in both layouts, so an
// arbiter can prepend or strip a client id at the top of opaque by splicing
// one bit just under the message MSB.
package mem_msg_pkg;

  localparam int c_cli_id_bits   = 1;
  localparam int c_mem_data_bits = 32;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_type_e;

  function automatic int mem_req_bits(input int opaq_bits, input int addr_bits);
    return 1 + opaq_bits + addr_bits + c_mem_data_bits;
  endfunction

  function automatic int mem_resp_bits(input int opaq_bits);
    return 1 + opaq_bits + c_mem_data_bits;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// rtl/rr_arb_2.sv - two-way round-robin arbitration decision
//
// Ports:
//   val   [1:0] in  : request valid per client
//   rr          in  : client favoured when both are valid
//   grant [1:0] out : one-hot grant (zero when no client is valid)
module rr_arb_2 (
  input  logic [1:0] val,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = val;
    if (val == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arb_2to1.sv
// rtl/mem_arb_2to1.sv - two-client memory request arbiter with response routing
//
// Optional feature: define MEM_ARB_STATS_EN to add per-client grant counters.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   cli_req_val/rdy/msg   : per-client request channels (MEM_REQ(p_opaq_bits))
//   cli_resp_val/rdy/msg  : per-client response channels (MEM_RESP(p_opaq_bits))
//   mem_req_val/rdy/msg   : merged request to memory (MEM_REQ(p_opaq_bits+1))
//   mem_resp_val/rdy/msg  : response from memory (MEM_RESP(p_opaq_bits+1))
//   grant_cnt[2]          : accepted-request count per client (MEM_ARB_STATS_EN)
module mem_arb_2to1
  import mem_msg_pkg::*;
#(
  parameter int p_opaq_bits = 8,
  parameter int p_addr_bits = 32
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [1:0]                                            cli_req_val,
  output logic [1:0]                                            cli_req_rdy,
  input  logic [1:0][mem_req_bits(p_opaq_bits, p_addr_bits)-1:0] cli_req_msg,
  output logic [1:0]                                            cli_resp_val,
  input  logic [1:0]                                            cli_resp_rdy,
  output logic [1:0][mem_resp_bits(p_opaq_bits)-1:0]           cli_resp_msg,
  output logic                                                  mem_req_val,
  input  logic                                                  mem_req_rdy,
  output logic [mem_req_bits(p_opaq_bits + c_cli_id_bits, p_addr_bits)-1:0] mem_req_msg,
  input  logic                                                  mem_resp_val,
  output logic                                                  mem_resp_rdy,
  input  logic [mem_resp_bits(p_opaq_bits + c_cli_id_bits)-1:0] mem_resp_msg
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [1:0][31:0]                                      grant_cnt
`endif
);

  localparam int c_creq_w  = mem_req_bits(p_opaq_bits, p_addr_bits);
  localparam int c_mreq_w  = mem_req_bits(p_opaq_bits + c_cli_id_bits, p_addr_bits);
  localparam int c_mresp_w = mem_resp_bits(p_opaq_bits + c_cli_id_bits);

  logic                slot_full;
  logic [c_mreq_w-1:0] slot_msg;
  logic                rr;
  logic [1:0]          grant;
  logic                can_accept;
  logic                accept;
  logic                gidx;
  logic [c_creq_w-1:0] gmsg;
  logic                resp_id;

  rr_arb_2 u_arb (
    .val   (cli_req_val),
    .rr    (rr),
    .grant (grant)
  );

  // The slot takes a new request when empty or when its current occupant
  // leaves this same cycle.
  assign can_accept  = !slot_full || mem_req_rdy;
  // rst gating keeps ready low for the whole reset window, not only after
  // the first clock edge.
  assign cli_req_rdy = (rst || !can_accept) ? 2'b00 : grant;
  assign accept      = |(cli_req_val & cli_req_rdy);
  assign gidx        = grant[1];
  assign gmsg        = cli_req_msg[gidx];

  assign mem_req_val = slot_full;
  assign mem_req_msg = slot_msg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full <= 1'b0;
      slot_msg  <= '0;
      rr        <= 1'b0;
    end else begin
      if (accept) begin
        slot_full <= 1'b1;
        // Client id becomes the new opaque MSB, just below the type bit.
        slot_msg  <= {gmsg[c_creq_w-1], gidx, gmsg[c_creq_w-2:0]};
        rr        <= ~gidx;
      end else if (mem_req_rdy) begin
        slot_full <= 1'b0;
      end
    end
  end

  // Response steering is purely combinational on the opaque MSB.
  assign resp_id      = mem_resp_msg[c_mresp_w-2];
  assign cli_resp_val = {mem_resp_val & resp_id, mem_resp_val & ~resp_id};
  assign cli_resp_msg = {2{mem_resp_msg[c_mresp_w-1], mem_resp_msg[c_mresp_w-3:0]}};
  assign mem_resp_rdy = cli_resp_rdy[resp_id];

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (accept) begin
      grant_cnt[gidx] <= grant_cnt[gidx] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb_2to1.sv
// tb/tb_mem_arb_2to1.sv - self-checking bench for mem_arb_2to1
module tb_mem_arb_2to1;

  localparam int CRW = 73;
  localparam int MRW = 74;
  localparam int CSW = 41;
  localparam int MSW = 42;

  logic                clk;
  logic                rst;
  logic [1:0]          cli_req_val;
  logic [1:0]          cli_req_rdy;
  logic [1:0][CRW-1:0] cli_req_msg;
  logic [1:0]          cli_resp_val;
  logic [1:0]          cli_resp_rdy;
  logic [1:0][CSW-1:0] cli_resp_msg;
  logic                mem_req_val;
  logic                mem_req_rdy;
  logic [MRW-1:0]      mem_req_msg;
  logic                mem_resp_val;
  logic                mem_resp_rdy;
  logic [MSW-1:0]      mem_resp_msg;
`ifdef MEM_ARB_STATS_EN
  logic [1:0][31:0]    grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mem_arb_2to1 #(.p_opaq_bits(8), .p_addr_bits(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cli_req_val  (cli_req_val),
    .cli_req_rdy  (cli_req_rdy),
    .cli_req_msg  (cli_req_msg),
    .cli_resp_val (cli_resp_val),
    .cli_resp_rdy (cli_resp_rdy),
    .cli_resp_msg (cli_resp_msg),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_msg  (mem_req_msg),
    .mem_resp_val (mem_resp_val),
    .mem_resp_rdy (mem_resp_rdy),
    .mem_resp_msg (mem_resp_msg)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [CRW-1:0] mk_creq(input logic t, input logic [7:0] o,
                                             input logic [31:0] a, input logic [31:0] d);
    return {t, o, a, d};
  endfunction

  function automatic logic [MRW-1:0] mk_mreq(input logic t, input logic [8:0] o,
                                             input logic [31:0] a, input logic [31:0] d);
    return {t, o, a, d};
  endfunction

  function automatic logic [CSW-1:0] mk_cresp(input logic t, input logic [7:0] o,
                                              input logic [31:0] d);
    return {t, o, d};
  endfunction

  function automatic logic [MSW-1:0] mk_mresp(input logic t, input logic [8:0] o,
                                              input logic [31:0] d);
    return {t, o, d};
  endfunction

  task automatic idle_inputs();
    cli_req_val  = 2'b00;
    cli_req_msg  = '0;
    cli_resp_rdy = 2'b00;
    mem_req_rdy  = 1'b0;
    mem_resp_val = 1'b0;
    mem_resp_msg = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cli_req_val  = 2'b11;
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_mresp(1'b0, 9'h100, 32'h55);
    cli_resp_rdy = 2'b10;
    #1;
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL reset_mem_req_val got=%b exp=0", mem_req_val); end
    checks++; if (cli_req_rdy !== 2'b00) begin failures++; $display("FAIL reset_cli_req_rdy got=%b exp=00", cli_req_rdy); end
    checks++; if (cli_resp_val !== 2'b10) begin failures++; $display("FAIL reset_resp_val got=%b exp=10", cli_resp_val); end
    checks++; if (mem_resp_rdy !== 1'b1) begin failures++; $display("FAIL reset_resp_rdy got=%b exp=1", mem_resp_rdy); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (grant_cnt !== '0) begin failures++; $display("FAIL reset_grant_cnt got=%h exp=0", grant_cnt); end
`endif
    cli_req_val  = 2'b00;
    mem_resp_val = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cli_req_val = 2'b11;
    #1;
    checks++; if (cli_req_rdy !== 2'b01) begin failures++; $display("FAIL post_reset_rr got=%b exp=01", cli_req_rdy); end
    cli_req_val = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    cli_req_val    = 2'b01;
    cli_req_msg[0] = mk_creq(1'b0, 8'h05, 32'h100, 32'hDEADBEEF);
    mem_req_rdy    = 1'b1;
    #1;
    checks++; if (cli_req_rdy !== 2'b01) begin failures++; $display("FAIL single_rdy got=%b exp=01", cli_req_rdy); end
    @(negedge clk);
    cli_req_val  = 2'b00;
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_mresp(1'b0, 9'h005, 32'h1234);
    cli_resp_rdy = 2'b11;
    #1;
    checks++; if (mem_req_val !== 1'b1) begin failures++; $display("FAIL single_val got=%b exp=1", mem_req_val); end
    checks++; if (mem_req_msg !== mk_mreq(1'b0, 9'h005, 32'h100, 32'hDEADBEEF)) begin failures++; $display("FAIL single_msg got=%h exp=%h", mem_req_msg, mk_mreq(1'b0, 9'h005, 32'h100, 32'hDEADBEEF)); end
    checks++; if (cli_resp_val !== 2'b01) begin failures++; $display("FAIL single_resp_val got=%b exp=01", cli_resp_val); end
    checks++; if (cli_resp_msg[0] !== mk_cresp(1'b0, 8'h05, 32'h1234)) begin failures++; $display("FAIL single_resp_msg got=%h exp=%h", cli_resp_msg[0], mk_cresp(1'b0, 8'h05, 32'h1234)); end
    checks++; if (mem_resp_rdy !== 1'b1) begin failures++; $display("FAIL single_resp_rdy got=%b exp=1", mem_resp_rdy); end
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", mem_req_val); end
  endtask

  task automatic test_alternate();
    logic [MRW-1:0] exp_msg;
    logic           g;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n > 0) begin
        #1;
        checks++; if (mem_req_val !== 1'b1) begin failures++; $display("FAIL alt_val n=%0d got=%b exp=1", n, mem_req_val); end
        checks++; if (mem_req_msg !== exp_msg) begin failures++; $display("FAIL alt_msg n=%0d got=%h exp=%h", n, mem_req_msg, exp_msg); end
      end
      if (n == 5) begin
        cli_req_val = 2'b00;
      end else begin
        g              = n[0];
        cli_req_val    = 2'b11;
        mem_req_rdy    = 1'b1;
        cli_req_msg[0] = mk_creq(1'b0, 8'h10 + 8'(n), 32'h200 + 32'(n), 32'hA0 + 32'(n));
        cli_req_msg[1] = mk_creq(1'b1, 8'h20 + 8'(n), 32'h300 + 32'(n), 32'hB0 + 32'(n));
        exp_msg = g ? mk_mreq(1'b1, {1'b1, 8'h20 + 8'(n)}, 32'h300 + 32'(n), 32'hB0 + 32'(n))
                    : mk_mreq(1'b0, {1'b0, 8'h10 + 8'(n)}, 32'h200 + 32'(n), 32'hA0 + 32'(n));
        #1;
        checks++; if (cli_req_rdy !== (g ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_grant n=%0d got=%b exp=%b", n, cli_req_rdy, (g ? 2'b10 : 2'b01)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [MRW-1:0] exp0;
    logic [MRW-1:0] exp1;
    do_reset();
    exp0 = mk_mreq(1'b1, 9'h011, 32'h400, 32'h1);
    exp1 = mk_mreq(1'b0, 9'h122, 32'h500, 32'h2);
    @(negedge clk);
    cli_req_val    = 2'b11;
    cli_req_msg[0] = mk_creq(1'b1, 8'h11, 32'h400, 32'h1);
    cli_req_msg[1] = mk_creq(1'b0, 8'h22, 32'h500, 32'h2);
    mem_req_rdy    = 1'b0;
    #1;
    checks++; if (cli_req_rdy !== 2'b01) begin failures++; $display("FAIL bp_fill_rdy got=%b exp=01", cli_req_rdy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++; if (cli_req_rdy !== 2'b00) begin failures++; $display("FAIL bp_hold_rdy c=%0d got=%b exp=00", c, cli_req_rdy); end
      checks++; if (mem_req_msg !== exp0 || mem_req_val !== 1'b1) begin failures++; $display("FAIL bp_hold_msg c=%0d got=%h exp=%h", c, mem_req_msg, exp0); end
    end
    @(negedge clk);
    mem_req_rdy = 1'b1;
    #1;
    checks++; if (cli_req_rdy !== 2'b10) begin failures++; $display("FAIL bp_release_rdy got=%b exp=10", cli_req_rdy); end
    @(negedge clk);
    cli_req_val = 2'b00;
    #1;
    checks++; if (mem_req_msg !== exp1 || mem_req_val !== 1'b1) begin failures++; $display("FAIL bp_second_msg got=%h exp=%h", mem_req_msg, exp1); end
    @(negedge clk);
    #1;
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", mem_req_val); end
  endtask

  task automatic test_resp_route();
    @(negedge clk);
    mem_resp_val = 1'b1;
    mem_resp_msg = mk_mresp(1'b1, 9'h1A3, 32'hCAFE);
    cli_resp_rdy = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (cli_resp_val !== 2'b10) begin failures++; $display("FAIL route_val c=%0d got=%b exp=10", c, cli_resp_val); end
      checks++; if (mem_resp_rdy !== 1'b0) begin failures++; $display("FAIL route_stall c=%0d got=%b exp=0", c, mem_resp_rdy); end
      @(negedge clk);
    end
    checks++; if (cli_resp_msg[1] !== mk_cresp(1'b1, 8'hA3, 32'hCAFE)) begin failures++; $display("FAIL route_msg got=%h exp=%h", cli_resp_msg[1], mk_cresp(1'b1, 8'hA3, 32'hCAFE)); end
    cli_resp_rdy = 2'b10;
    #1;
    checks++; if (mem_resp_rdy !== 1'b1) begin failures++; $display("FAIL route_release got=%b exp=1", mem_resp_rdy); end
    mem_resp_val = 1'b0;
    cli_resp_rdy = 2'b00;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    cli_req_val    = 2'b01;
    cli_req_msg[0] = mk_creq(1'b0, 8'h33, 32'h600, 32'h3);
    mem_req_rdy    = 1'b0;
    @(negedge clk);
    cli_req_val = 2'b00;
    #1;
    checks++; if (mem_req_val !== 1'b1) begin failures++; $display("FAIL ar_filled got=%b exp=1", mem_req_val); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL ar_async_drop got=%b exp=0", mem_req_val); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (grant_cnt !== '0) begin failures++; $display("FAIL ar_grant_cnt got=%h exp=0", grant_cnt); end
`endif
    @(negedge clk);
    rst         = 1'b0;
    cli_req_val = 2'b11;
    #1;
    checks++; if (cli_req_rdy !== 2'b01) begin failures++; $display("FAIL ar_rr got=%b exp=01", cli_req_rdy); end
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL ar_discard got=%b exp=0", mem_req_val); end
    cli_req_val = 2'b00;
  endtask

  task automatic test_random();
    logic [MRW-1:0] q[$];
    logic [MRW-1:0] head;
    logic           tb_rr;
    logic [1:0]     exp_g;
    logic [1:0]     exp_rdy;
    logic           k;
    int             acc[2];
    do_reset();
    tb_rr  = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      cli_req_val    = 2'($urandom);
      cli_req_msg[0] = mk_creq(1'($urandom), 8'($urandom), $urandom, $urandom);
      cli_req_msg[1] = mk_creq(1'($urandom), 8'($urandom), $urandom, $urandom);
      mem_req_rdy    = 1'($urandom);
      mem_resp_val   = 1'($urandom);
      mem_resp_msg   = mk_mresp(1'($urandom), 9'($urandom), $urandom);
      cli_resp_rdy   = 2'($urandom);
      #1;
      exp_g   = (cli_req_val == 2'b11) ? (tb_rr ? 2'b10 : 2'b01) : cli_req_val;
      exp_rdy = (q.size() == 0 || mem_req_rdy) ? exp_g : 2'b00;
      checks++; if (cli_req_rdy !== exp_rdy) begin failures++; if (failures < 20) $display("FAIL rand_req_rdy c=%0d got=%b exp=%b", c, cli_req_rdy, exp_rdy); end
      checks++; if (mem_req_val !== (q.size() != 0)) begin failures++; if (failures < 20) $display("FAIL rand_req_val c=%0d got=%b exp=%b", c, mem_req_val, (q.size() != 0)); end
      if (q.size() != 0) begin
        head = q[0];
        checks++; if (mem_req_msg !== head) begin failures++; if (failures < 20) $display("FAIL rand_req_msg c=%0d got=%h exp=%h", c, mem_req_msg, head); end
        if (mem_req_rdy) void'(q.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (cli_req_val[i] && exp_rdy[i]) begin
          q.push_back({cli_req_msg[i][CRW-1], i[0], cli_req_msg[i][CRW-2:0]});
          acc[i]++;
          tb_rr = ~i[0];
        end
      end
      k = mem_resp_msg[MSW-2];
      checks++; if (cli_resp_val !== (mem_resp_val ? (k ? 2'b10 : 2'b01) : 2'b00)) begin failures++; if (failures < 20) $display("FAIL rand_resp_val c=%0d got=%b", c, cli_resp_val); end
      checks++; if (mem_resp_rdy !== cli_resp_rdy[k]) begin failures++; if (failures < 20) $display("FAIL rand_resp_rdy c=%0d got=%b exp=%b", c, mem_resp_rdy, cli_resp_rdy[k]); end
      checks++; if (cli_resp_msg[k] !== {mem_resp_msg[MSW-1], mem_resp_msg[MSW-3:0]}) begin failures++; if (failures < 20) $display("FAIL rand_resp_msg c=%0d got=%h", c, cli_resp_msg[k]); end
    end
    @(negedge clk);
    idle_inputs();
    mem_req_rdy = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (mem_req_val !== 1'b0) begin failures++; $display("FAIL rand_flush got=%b exp=0", mem_req_val); end
    checks++; if (acc[0] == 0 || acc[1] == 0) begin failures++; $display("FAIL rand_activity got=%0d,%0d exp=nonzero", acc[0], acc[1]); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (grant_cnt[0] !== 32'(acc[0])) begin failures++; $display("FAIL rand_cnt0 got=%0d exp=%0d", grant_cnt[0], acc[0]); end
    checks++; if (grant_cnt[1] !== 32'(acc[1])) begin failures++; $display("FAIL rand_cnt1 got=%0d exp=%0d", grant_cnt[1], acc[1]); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_resp_route();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb_2to1.md
MEM_ARB_2TO1 -- requirements
Module: mem_arb_2to1

Interface
REQ-001 The block SHALL have parameter p_opaq_bits, default 8, giving the client-side opaque width; the memory-side opaque width is p_opaq_bits+1.
REQ-002 The block SHALL have parameter p_addr_bits, default 32, giving the request address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cli_req_val, input, 2 bits: per-client request valid.
REQ-006 The block SHALL have port cli_req_rdy, output, 2 bits: per-client request ready.
REQ-007 The block SHALL have port cli_req_msg, input, 2 x MEM_REQ(p_opaq_bits): per-client request.
REQ-008 The block SHALL have port cli_resp_val, output, 2 bits: per-client response valid.
REQ-009 The block SHALL have port cli_resp_rdy, input, 2 bits: per-client response ready.
REQ-010 The block SHALL have port cli_resp_msg, output, 2 x MEM_RESP(p_opaq_bits): per-client response.
REQ-011 The block SHALL have port mem_req_val / mem_req_rdy / mem_req_msg, output / input / output, 1 / 1 / MEM_REQ(p_opaq_bits+1) bits: merged memory-side request.
REQ-012 The block SHALL have port mem_resp_val / mem_resp_rdy / mem_resp_msg, input / output / input, 1 / 1 / MEM_RESP(p_opaq_bits+1) bits: memory-side response.

Function
REQ-013 The block SHALL transfer on any val/rdy channel only in a cycle where val and rdy are both high; val SHALL NOT depend combinationally on rdy of the same channel.
REQ-014 The block SHALL hold one registered request slot; mem_req_val equals slot-full, and mem_req_msg is driven only from the slot register.
REQ-015 The slot SHALL accept a new request when empty, or when full and being drained (mem_req_val && mem_req_rdy) in the same cycle; request latency is exactly 1 cycle.
REQ-016 The block SHALL assert cli_req_rdy[i] only for the single granted client and only when the slot can accept.
REQ-017 The block SHALL grant the sole valid client when exactly one cli_req_val bit is high.
REQ-018 The block SHALL grant the client named by the round-robin pointer rr when both are valid.
REQ-019 After each accepted request from client i, rr SHALL become 1-i; rr SHALL NOT change otherwise.
REQ-020 On acceptance the slot SHALL store the client message with opaque = {i, cli opaque}, all other fields unmodified.
REQ-021 The response path SHALL be combinational: cli_resp_val[k] = mem_resp_val && (opaque MSB == k).
REQ-022 cli_resp_msg[k] SHALL carry mem_resp_msg with the MSB stripped, and mem_resp_rdy = cli_resp_rdy[MSB].
REQ-023 Requests and responses SHALL proceed independently in the same cycle; there is no outstanding-request limit inside the block.

Reset
REQ-024 Reset SHALL asynchronously clear the slot (mem_req_val=0) and set rr=0.
REQ-025 During reset cli_req_rdy SHALL be 0; response outputs follow REQ-021/022 combinationally.
REQ-026 A request held in the slot when reset asserts SHALL be discarded; in-flight responses are not the block's concern.

Configuration
REQ-027 With MEM_ARB_STATS_EN defined, the block SHALL add outputs grant_cnt[2], 32 bits each: each counts accepted requests per client, wraps at 2^32, and resets to 0.
REQ-028 Without MEM_ARB_STATS_EN, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-029 The MEM_REQ/MEM_RESP message definitions and the client-id width constant (1) SHALL live in the shared memory-interface package; no new package is created.
REQ-030 The arbitration decision SHALL be one sub-module, rr_arb_2, taking val[2] and rr and giving a one-hot grant; everything else stays in mem_arb_2to1.

Verification
REQ-031 Client 0 read with opaque 0x05 to addr 0x100, mem_req_rdy=1 -> mem_req_val the next cycle, opaque 0x005; a response with opaque 0x005 -> cli_resp_val=2'b01, opaque 0x05.
REQ-032 Both clients valid every cycle, rr=0, mem_req_rdy=1 -> grants alternate 0,1,0,1 and mem_req_val stays high continuously.
REQ-033 mem_req_rdy=0 for 5 cycles with both clients valid -> the slot holds the first request, cli_req_rdy=2'b00 after the fill, and no message is lost or duplicated.
REQ-034 A response with opaque 0x1A3 while cli_resp_rdy=2'b01 -> cli_resp_val[1]=1 and mem_resp_rdy=0 until cli_resp_rdy[1] is raised.
REQ-035 Reset asserted mid-cycle with the slot full -> mem_req_val drops immediately (asynchronously), rr=0, and grant_cnt reads 0 when MEM_ARB_STATS_EN is defined.
REQ-036 Random val/rdy on all channels for 10000 cycles, checked against a scoreboard -> per-client request order and responses are preserved, and with MEM_ARB_STATS_EN the grant_cnt values equal the accepted totals.
